// File: rtl/vga_sync_gen_if.sv
`timescale 1ns/1ps
// vga_sync_gen_if: sync, strobe and pixel-coordinate bundle from the VGA timing generator
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       line_tick;
  logic       frame_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  modport master (output hsync, vsync, video_on, p_tick, line_tick, frame_tick, pixel_x, pixel_y);
  modport slave (input hsync, vsync, video_on, p_tick, line_tick, frame_tick, pixel_x, pixel_y);
endinterface

// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// vga_sync_gen: 640x480@60Hz VGA timing generator with clk-to-pixel divider
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  logic          run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          tick, h_end, v_end;
  always_comb begin
    tick  = run_q && div_q == DIV_MAX;
    h_end = x_q == H_MAX;
    v_end = y_q == V_MAX;
    run_d = 1'b1;
    div_d = tick || !run_q ? '0 : div_q + DW'(1);
    x_d   = tick ? (h_end ? '0 : x_q + 10'd1) : x_q;
    y_d   = tick && h_end ? (v_end ? '0 : y_q + 10'd1) : y_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end
  // decodes come straight off the registered counters so all outputs share one alignment
  always_comb begin
    vga.p_tick     = tick;
    vga.line_tick  = tick && h_end;
    vga.frame_tick = tick && h_end && v_end;
    vga.video_on   = run_q && x_q < H_VIS && y_q < V_VIS;
    vga.hsync      = !(run_q && x_q >= HS_LO && x_q <= HS_HI);
    vga.vsync      = !(run_q && y_q >= VS_LO && y_q <= VS_HI);
    vga.pixel_x    = x_q;
    vga.pixel_y    = y_q;
  end
endmodule
